pixel_src: RTL

- Raster timing generator and test-pattern pixel transmitter.
- Produces the pixel stream that the filter chain (blur/gauss path) consumes: pixel word, column index, horizontal count, line and frame markers.
- Used on the bench and on the board in place of the camera path for deterministic filter bring-up.
- All outputs are registered and mutually coherent in the same cycle.

---
 rtl/pixel_src.sv | 115 +++++++++++
 1 files changed

// File: rtl/pixel_src.sv
// Raster timing generator with test-pattern pixels; outputs registered, 1 cycle after the (x,y) they describe.
// No backpressure: en=0 freezes the raster, holds data outputs and drops the valid/marker pulses.
module pixel_src #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 160,
   parameter int V_ACTIVE = 480,
   parameter int V_BLANK  = 45,
   parameter int BAR_W    = 80,
   parameter int CHK_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [1:0]  pat_sel,
   output logic [23:0] pixel_out,
   output logic        pixel_valid,
   output logic [12:0] col,
   output logic [12:0] x_count,
   output logic [12:0] y_count,
   output logic        line_end,
   output logic        frame_start,
   output logic        frame_end
);

   localparam logic [12:0] H_LAST     = 13'(H_ACTIVE + H_BLANK - 1);
   localparam logic [12:0] V_LAST     = 13'(V_ACTIVE + V_BLANK - 1);
   localparam logic [12:0] H_ACT      = 13'(H_ACTIVE);
   localparam logic [12:0] V_ACT      = 13'(V_ACTIVE);
   localparam logic [12:0] H_ACT_LAST = 13'(H_ACTIVE - 1);
   localparam logic [12:0] V_ACT_LAST = 13'(V_ACTIVE - 1);
   localparam logic [12:0] BAR_LAST   = 13'(BAR_W - 1);

   logic [12:0] x, y, bar_cnt;
   logic [2:0]  bar_idx;
   logic [1:0]  pat_q;
   logic        active, origin;
   logic [1:0]  pat_cur;
   logic [23:0] pix_nxt;

   always_comb begin
      active  = (x < H_ACT) && (y < V_ACT);
      origin  = (x == 13'd0) && (y == 13'd0);
      // pat_sel is taken live at the origin so pixel (0,0) already uses the new pattern
      pat_cur = origin ? pat_sel : pat_q;
      pix_nxt = 24'h000000;
      if (active) begin
         case (pat_cur)
            2'd0: pix_nxt = 24'h808080;
            2'd1: begin
               case (bar_idx)
                  3'd0:    pix_nxt = 24'hFFFFFF;
                  3'd1:    pix_nxt = 24'hFFFF00;
                  3'd2:    pix_nxt = 24'h00FFFF;
                  3'd3:    pix_nxt = 24'h00FF00;
                  3'd4:    pix_nxt = 24'hFF00FF;
                  3'd5:    pix_nxt = 24'hFF0000;
                  3'd6:    pix_nxt = 24'h0000FF;
                  default: pix_nxt = 24'h000000;
               endcase
            end
            2'd2:    pix_nxt = {x[7:0], x[7:0], y[7:0]};
            default: pix_nxt = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x           <= 13'd0;
         y           <= 13'd0;
         bar_cnt     <= 13'd0;
         bar_idx     <= 3'd0;
         pat_q       <= 2'd0;
         pixel_out   <= 24'h000000;
         pixel_valid <= 1'b0;
         col         <= 13'd0;
         x_count     <= 13'd0;
         y_count     <= 13'd0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end else if (en) begin
         pixel_out   <= pix_nxt;
         pixel_valid <= active;
         col         <= active ? x : 13'd0;
         x_count     <= x;
         y_count     <= y;
         line_end    <= active && (x == H_ACT_LAST);
         frame_end   <= active && (x == H_ACT_LAST) && (y == V_ACT_LAST);
         frame_start <= origin;
         if (origin) pat_q <= pat_sel;
         // bar index tracks x by counting BAR_W-wide runs instead of dividing
         if (x == H_LAST) begin
            x       <= 13'd0;
            bar_cnt <= 13'd0;
            bar_idx <= 3'd0;
            y       <= (y == V_LAST) ? 13'd0 : y + 13'd1;
         end else begin
            x <= x + 13'd1;
            if (bar_cnt == BAR_LAST) begin
               bar_cnt <= 13'd0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_cnt <= bar_cnt + 13'd1;
            end
         end
      end else begin
         pixel_valid <= 1'b0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end
   end

endmodule
